// File: rtl/jtbubl_pkg.sv
// Shared constants and types for the main/sound communication mailbox.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package jtbubl_pkg;

  // Sound-side register window addresses
  localparam logic [1:0] COMM_DATA   = 2'd0;
  localparam logic [1:0] COMM_NMION  = 2'd1;
  localparam logic [1:0] COMM_NMIOFF = 2'd2;

  // Bit positions inside main_st
  localparam int ST_SND  = 0;
  localparam int ST_MAIN = 1;
  localparam int ST_OVR  = 2;

  // NMI pulse generator states
  typedef enum logic {
    NMI_IDLE  = 1'b0,
    NMI_PULSE = 1'b1
  } nmi_st_t;

endpackage

// File: rtl/jtbubl_comm_if.sv
// Bundle of main-CPU and sound-CPU mailbox signals.
// Latency: n/a (wiring only).
// Backpressure: none; flags in main_st/snd_dout tell each side when data is waiting.
interface jtbubl_comm_if;
  logic       main_wr;
  logic       main_rd;
  logic [7:0] main_din;
  logic [7:0] main_dout;
  logic [2:0] main_st;
  logic       snd_cs;
  logic       snd_rnw;
  logic [1:0] snd_addr;
  logic [7:0] snd_din;
  logic [7:0] snd_dout;
  logic       snd_nmi_n;

  // CPU side: drives strobes and data, observes latches, flags and NMI
  modport master (
    output main_wr, main_rd, main_din, snd_cs, snd_rnw, snd_addr, snd_din,
    input  main_dout, main_st, snd_dout, snd_nmi_n
  );

  // Mailbox side
  modport slave (
    input  main_wr, main_rd, main_din, snd_cs, snd_rnw, snd_addr, snd_din,
    output main_dout, main_st, snd_dout, snd_nmi_n
  );
endinterface

// File: rtl/jtbubl_comm_nmi.sv
// Sound NMI generator: pending flag plus fixed-length active-low pulse.
// Latency: pulse starts on the first snd_cen tick with pending & enabled; lasts NMI_LEN ticks.
// Backpressure: requests arriving mid-pulse stay pending and produce one further pulse.
module jtbubl_comm_nmi
  import jtbubl_pkg::*;
#(
  parameter int NMI_LEN = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic cen,
  input  logic set_pend,
  input  logic nmi_en,
  output logic nmi_n
);

  localparam logic [7:0] CNT_LOAD = 8'(NMI_LEN - 1);

  nmi_st_t    state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       nmi_n_q, nmi_n_d;
  logic       take;

  // Next state: launch a pulse from IDLE, count it down in PULSE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nmi_n_d = nmi_n_q;
    take    = 1'b0;
    case (state_q)
      NMI_IDLE: begin
        if (cen && pend_q && nmi_en) begin
          state_d = NMI_PULSE;
          nmi_n_d = 1'b0;
          cnt_d   = CNT_LOAD;
          take    = 1'b1;
        end
      end
      NMI_PULSE: begin
        // nmi_en is deliberately ignored here so a running pulse always completes
        if (cen) begin
          if (cnt_q == 8'd0) begin
            state_d = NMI_IDLE;
            nmi_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = NMI_IDLE;
        nmi_n_d = 1'b1;
      end
    endcase
    // A new command in the same cycle as a launch must not be lost
    if (set_pend)  pend_d = 1'b1;
    else if (take) pend_d = 1'b0;
    else           pend_d = pend_q;
  end

  // State register; reset releases the NMI line immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= NMI_IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= 1'b0;
      nmi_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      nmi_n_q <= nmi_n_d;
    end
  end

  assign nmi_n = nmi_n_q;

endmodule

// File: rtl/jtbubl_comm.sv
// Main<->sound mailbox: one byte latch and full flag per direction, overrun flag, NMI enable.
// Latency: latches/flags update one clk after the strobe edge; snd_dout is combinational.
// Backpressure: none; a second main write before the sound read overwrites and sets overrun.
module jtbubl_comm
  import jtbubl_pkg::*;
#(
  parameter int NMI_LEN = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          snd_cen,
  jtbubl_comm_if.slave  bus
);

  logic       main_wr_q, main_wr_d;
  logic       main_rd_q, main_rd_d;
  logic       snd_done_q, snd_done_d;
  logic [7:0] snd_latch_q, snd_latch_d;
  logic [7:0] main_latch_q, main_latch_d;
  logic       snd_flag_q, snd_flag_d;
  logic       main_flag_q, main_flag_d;
  logic       overrun_q, overrun_d;
  logic       nmi_en_q, nmi_en_d;

  logic       wr_edge, rd_edge;
  logic       snd_acc, snd_rd0, snd_wr;
  logic [7:0] snd_dout_c;

  assign wr_edge = bus.main_wr & ~main_wr_q;
  assign rd_edge = bus.main_rd & ~main_rd_q;
  // One effective sound access per snd_cs assertion
  assign snd_acc = bus.snd_cs & snd_cen & ~snd_done_q;
  assign snd_rd0 = snd_acc & bus.snd_rnw & (bus.snd_addr == COMM_DATA);
  assign snd_wr  = snd_acc & ~bus.snd_rnw;

  // Latch and flag updates; main writes and sound writes win over same-cycle reads
  always_comb begin
    main_wr_d    = bus.main_wr;
    main_rd_d    = bus.main_rd;
    snd_done_d   = bus.snd_cs & (snd_done_q | snd_cen);
    snd_latch_d  = snd_latch_q;
    main_latch_d = main_latch_q;
    snd_flag_d   = snd_flag_q;
    main_flag_d  = main_flag_q;
    overrun_d    = overrun_q;
    nmi_en_d     = nmi_en_q;

    if (snd_rd0) snd_flag_d = 1'b0;
    if (rd_edge) begin
      main_flag_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (wr_edge) begin
      snd_latch_d = bus.main_din;
      snd_flag_d  = 1'b1;
      if (snd_flag_q) overrun_d = 1'b1;
    end
    if (snd_wr) begin
      case (bus.snd_addr)
        COMM_DATA: begin
          main_latch_d = bus.snd_din;
          main_flag_d  = 1'b1;
        end
        COMM_NMION:  nmi_en_d = 1'b1;
        COMM_NMIOFF: nmi_en_d = 1'b0;
        default:     nmi_en_d = nmi_en_q;
      endcase
    end
  end

  // Register bank
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_wr_q    <= 1'b0;
      main_rd_q    <= 1'b0;
      snd_done_q   <= 1'b0;
      snd_latch_q  <= 8'h00;
      main_latch_q <= 8'h00;
      snd_flag_q   <= 1'b0;
      main_flag_q  <= 1'b0;
      overrun_q    <= 1'b0;
      nmi_en_q     <= 1'b0;
    end else begin
      main_wr_q    <= main_wr_d;
      main_rd_q    <= main_rd_d;
      snd_done_q   <= snd_done_d;
      snd_latch_q  <= snd_latch_d;
      main_latch_q <= main_latch_d;
      snd_flag_q   <= snd_flag_d;
      main_flag_q  <= main_flag_d;
      overrun_q    <= overrun_d;
      nmi_en_q     <= nmi_en_d;
    end
  end

  // Sound read mux, no read latency
  always_comb begin
    snd_dout_c = 8'hFF;
    case (bus.snd_addr)
      COMM_DATA:  snd_dout_c = snd_latch_q;
      COMM_NMION: snd_dout_c = {6'b0, main_flag_q, snd_flag_q};
      default:    snd_dout_c = 8'hFF;
    endcase
  end

  assign bus.snd_dout  = snd_dout_c;
  assign bus.main_dout = main_latch_q;
  always_comb begin
    bus.main_st          = 3'b000;
    bus.main_st[ST_SND]  = snd_flag_q;
    bus.main_st[ST_MAIN] = main_flag_q;
    bus.main_st[ST_OVR]  = overrun_q;
  end

  jtbubl_comm_nmi #(
    .NMI_LEN (NMI_LEN)
  ) u_nmi (
    .clk      (clk),
    .rstn     (rstn),
    .cen      (snd_cen),
    .set_pend (wr_edge),
    .nmi_en   (nmi_en_q),
    .nmi_n    (bus.snd_nmi_n)
  );

endmodule
